cdc_loop_fifo: RTL and testbench
================================

CDC_LOOP_FIFO -- requirements
Module: cdc_loop_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of FIFO entries (DEPTH = 16).
REQ-002 SHALL have parameter WIDTH, default 8, payload bits per entry.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush_i  input  1  synchronous clear of contents and statistics.
REQ-006 SHALL have port in_valid_i  input  1  upstream byte valid (from USB CDC outport).
REQ-007 SHALL have port in_data_i  input  WIDTH  upstream byte.
REQ-008 SHALL have port in_accept_o  output  1  FIFO takes byte this cycle.
REQ-009 SHALL have port out_valid_o  output  1  head byte available (to USB CDC inport).
REQ-010 SHALL have port out_data_o  output  WIDTH  head byte.
REQ-011 SHALL have port out_accept_i  input  1  downstream takes head byte.
REQ-012 SHALL have port level_o  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have port max_level_o  output  DEPTH_LOG2+1  high-water mark since reset/flush.

Function
REQ-014 SHALL be a synchronous FIFO of DEPTH entries: register array, read pointer, write pointer (DEPTH_LOG2 bits each), occupancy counter.
REQ-015 SHALL drive in_accept_o = (level_o != DEPTH) and out_valid_o = (level_o != 0), both decoded from registered state only.
REQ-016 SHALL push when in_valid_i && in_accept_o: write entry at the write pointer, then increment the write pointer modulo DEPTH.
REQ-017 SHALL pop when out_valid_o && out_accept_i: increment the read pointer modulo DEPTH.
REQ-018 SHALL drive out_data_o = entry at the read pointer (first-word fall-through); the value is held stable while out_valid_o=1 and no pop occurs.
REQ-019 SHALL have latency 1: a byte pushed into an empty FIFO at cycle N presents out_valid_o=1 at cycle N+1.
REQ-020 SHALL update level: push only +1; pop only -1; push and pop together unchanged.
REQ-021 SHALL NOT bypass when full: in_accept_o=0 even if a pop occurs in the same cycle.
REQ-022 SHALL wrap pointers from DEPTH-1 to 0 with no bubble or data loss.
REQ-023 SHALL update max_level_o each cycle to max(max_level_o, next level).
REQ-024 SHALL give flush_i priority over push and pop: next cycle pointers, level_o and max_level_o = 0, and that cycle's push/pop is discarded.
REQ-025 SHALL never lose or duplicate bytes; output order SHALL equal accepted input order.

Reset
REQ-026 SHALL, on rst_n_i=0, asynchronously clear pointers, level_o and max_level_o to 0, which yields out_valid_o=0 and in_accept_o=1.
REQ-027 SHALL NOT reset the storage array; out_data_o is don't-care while out_valid_o=0.
REQ-028 SHALL discard all contents on reset asserted mid-transfer; operation resumes from empty on the first edge after release.

Configuration
REQ-029 SHALL, when macro CDC_LOOP_FIFO_CASE_SWAP_EN is defined, store in_data_i[7:0] with bit 5 inverted if it is ASCII 0x41-0x5A or 0x61-0x7A, and unchanged otherwise; bits above 7 pass unchanged.
REQ-030 SHALL, when CDC_LOOP_FIFO_CASE_SWAP_EN is undefined, store in_data_i unmodified and contain no swap logic.

Verification
REQ-031 SHALL cover: reset, then push 0x55 with out_accept_i=0 -> out_valid_o=1 and out_data_o=0x55 on the next cycle; level_o=1.
REQ-032 SHALL cover: 16 pushes 0x00..0x0F with out_accept_i=0 -> in_accept_o=0 after the 16th push; level_o=16; max_level_o=16; a 17th byte 0xAA is not taken.
REQ-033 SHALL cover: FIFO full, in_valid_i=1, out_accept_i=1 for one cycle -> 0x00 popped, no push, level_o=15; in_accept_o=1 on the next cycle.
REQ-034 SHALL cover: streaming 40 bytes with random valid/accept -> output sequence equals input sequence across pointer wrap; level_o never exceeds 16.
REQ-035 SHALL cover: level_o=5, flush_i=1 with simultaneous push -> next cycle level_o=0, max_level_o=0, out_valid_o=0.
REQ-036 SHALL cover: with CDC_LOOP_FIFO_CASE_SWAP_EN defined, push 0x41, 0x7A, 0x31 -> pop 0x61, 0x5A, 0x31; without the macro -> pop 0x41, 0x7A, 0x31.

Source files
------------

// File: rtl/cdc_loop_fifo.sv
// Single-clock loopback FIFO between USB CDC out/in ports with occupancy and high-water statistics.
// Optional ASCII case swap on write is enabled by defining CDC_LOOP_FIFO_CASE_SWAP_EN.
module cdc_loop_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  input  logic [WIDTH-1:0]      in_data_i,
  output logic                  in_accept_o,
  output logic                  out_valid_o,
  output logic [WIDTH-1:0]      out_data_o,
  input  logic                  out_accept_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic [DEPTH_LOG2:0]   max_level_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [LW-1:0]    max_level_q, max_level_d;
  logic [WIDTH-1:0] wr_data;
  logic             push, pop;

  // Handshake flags come from registered occupancy only; no bypass when full.
  assign in_accept_o = (level_q != LW'(DEPTH));
  assign out_valid_o = (level_q != LW'(0));
  assign out_data_o  = mem_q[rd_ptr_q];
  assign level_o     = level_q;
  assign max_level_o = max_level_q;

  assign push = in_valid_i && in_accept_o && !flush_i;
  assign pop  = out_valid_o && out_accept_i && !flush_i;

`ifdef CDC_LOOP_FIFO_CASE_SWAP_EN
  // Toggle bit 5 of ASCII letters; everything else passes through.
  logic [7:0] lo_byte;
  logic       is_alpha;
  always_comb begin
    lo_byte  = in_data_i[7:0];
    is_alpha = ((lo_byte >= 8'h41) && (lo_byte <= 8'h5A)) ||
               ((lo_byte >= 8'h61) && (lo_byte <= 8'h7A));
    wr_data  = in_data_i;
    if (is_alpha) begin
      wr_data[5] = ~in_data_i[5];
    end
  end
`else
  assign wr_data = in_data_i;
`endif

  // Next-state for pointers, occupancy and high-water mark.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    max_level_d = max_level_q;
    if (flush_i) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      level_d     = '0;
      max_level_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        level_d = level_q + LW'(1);
      end else if (pop && !push) begin
        level_d = level_q - LW'(1);
      end
      if (level_d > max_level_q) begin
        max_level_d = level_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      max_level_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      max_level_q <= max_level_d;
    end
  end

  // Storage is intentionally not reset; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_cdc_loop_fifo.sv
// Directed self-checking bench for cdc_loop_fifo: fill/full, pop-when-full, random stream, flush, reset, case swap.
module tb_cdc_loop_fifo;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       flush_i;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_accept_o;
  logic       out_valid_o;
  logic [7:0] out_data_o;
  logic       out_accept_i;
  logic [4:0] level_o;
  logic [4:0] max_level_o;

  int n_vec = 0;
  int n_err = 0;

  cdc_loop_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_accept_o  (in_accept_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_accept_i (out_accept_i),
    .level_o      (level_o),
    .max_level_o  (max_level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [7:0] sb_q[$];
  logic [7:0] exp_b;
  int         model_lvl;
  int         model_max;
  int         sent;
  int         rcvd;
  int         cyc;
  logic       v, a;
  logic [7:0] swap_in  [3];
  logic [7:0] swap_out [3];

  initial begin
    rst_n_i      = 1'b0;
    flush_i      = 1'b0;
    in_valid_i   = 1'b0;
    in_data_i    = 8'h00;
    out_accept_i = 1'b0;
    repeat (3) tick();
    check_val("rst_level", level_o, 0);
    check_val("rst_max", max_level_o, 0);
    check_val("rst_out_valid", out_valid_o, 0);
    check_val("rst_in_accept", in_accept_o, 1);
    rst_n_i = 1'b1;
    tick();

    // Single push, latency 1
    in_valid_i = 1'b1; in_data_i = 8'h55;
    tick();
    in_valid_i = 1'b0;
    check_val("single_out_valid", out_valid_o, 1);
    check_val("single_out_data", out_data_o, 8'h55);
    check_val("single_level", level_o, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_val("flush1_level", level_o, 0);
    check_val("flush1_max", max_level_o, 0);

    // Fill to full
    for (int i = 0; i < 16; i++) begin
      in_valid_i = 1'b1; in_data_i = 8'(i);
      check_val("fill_accept", in_accept_o, 1);
      tick();
    end
    in_data_i = 8'hAA;
    check_val("full_in_accept", in_accept_o, 0);
    check_val("full_level", level_o, 16);
    check_val("full_max", max_level_o, 16);
    tick();
    check_val("full_17th_level", level_o, 16);
    check_val("full_head", out_data_o, 8'h00);

    // Pop while full with upstream valid: no bypass
    out_accept_i = 1'b1;
    check_val("popfull_in_accept", in_accept_o, 0);
    tick();
    out_accept_i = 1'b0; in_valid_i = 1'b0;
    check_val("popfull_level", level_o, 15);
    check_val("popfull_in_accept_next", in_accept_o, 1);
    check_val("popfull_max", max_level_o, 16);
    for (int i = 1; i < 16; i++) begin
      out_accept_i = 1'b1;
      check_val("drain_data", out_data_o, 8'(i));
      tick();
    end
    out_accept_i = 1'b0;
    check_val("drain_level", level_o, 0);
    check_val("drain_out_valid", out_valid_o, 0);

    // Random stream across pointer wrap; bytes >= 0x80 are never letters
    model_lvl = 0; model_max = 16; sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 40 && cyc < 2000) begin
      v = ($urandom_range(0, 2) != 0) && (sent < 40);
      a = ($urandom_range(0, 2) != 0);
      in_valid_i   = v;
      in_data_i    = {1'b1, 7'($urandom)};
      out_accept_i = a;
      check_val("stream_level", level_o, model_lvl);
      check_val("stream_in_accept", in_accept_o, (model_lvl != 16));
      check_val("stream_out_valid", out_valid_o, (model_lvl != 0));
      if (a && model_lvl != 0) begin
        exp_b = sb_q.pop_front();
        check_val("stream_data", out_data_o, exp_b);
        rcvd++;
      end
      if (v && model_lvl != 16) begin
        sb_q.push_back(in_data_i);
        sent++;
      end
      model_lvl = sb_q.size();
      tick();
      cyc++;
    end
    in_valid_i = 1'b0; out_accept_i = 1'b0;
    check_val("stream_complete", rcvd, 40);
    check_val("stream_end_level", level_o, model_lvl);
    check_val("stream_max", max_level_o, model_max);

    // Flush at level 5 with simultaneous push
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1; in_data_i = 8'h90 + 8'(i);
      tick();
    end
    check_val("preflush_level", level_o, 5);
    flush_i = 1'b1; in_valid_i = 1'b1; in_data_i = 8'hEE;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check_val("flush_level", level_o, 0);
    check_val("flush_max", max_level_o, 0);
    check_val("flush_out_valid", out_valid_o, 0);
    check_val("flush_in_accept", in_accept_o, 1);

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1; in_data_i = 8'hA0 + 8'(i);
      tick();
    end
    #2 rst_n_i = 1'b0;
    #1;
    check_val("async_rst_level", level_o, 0);
    check_val("async_rst_out_valid", out_valid_o, 0);
    check_val("async_rst_max", max_level_o, 0);
    in_valid_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    in_valid_i = 1'b1; in_data_i = 8'hC3;
    tick();
    in_valid_i = 1'b0;
    check_val("post_rst_level", level_o, 1);
    check_val("post_rst_data", out_data_o, 8'hC3);
    out_accept_i = 1'b1;
    tick();
    out_accept_i = 1'b0;
    check_val("post_rst_empty", level_o, 0);

    // Case swap behaviour
    swap_in[0] = 8'h41; swap_in[1] = 8'h7A; swap_in[2] = 8'h31;
`ifdef CDC_LOOP_FIFO_CASE_SWAP_EN
    swap_out[0] = 8'h61; swap_out[1] = 8'h5A; swap_out[2] = 8'h31;
`else
    swap_out[0] = 8'h41; swap_out[1] = 8'h7A; swap_out[2] = 8'h31;
`endif
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1; in_data_i = swap_in[i];
      tick();
    end
    in_valid_i = 1'b0;
    check_val("swap_level", level_o, 3);
    for (int i = 0; i < 3; i++) begin
      out_accept_i = 1'b1;
      check_val("swap_data", out_data_o, swap_out[i]);
      tick();
    end
    out_accept_i = 1'b0;
    check_val("swap_end_level", level_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
